// File: rtl/data_memory_interface.sv
// Data memory interface: takes one load/store request at a time from the
// memory stage, checks alignment, drives a valid/ready bus request, waits a
// bounded number of cycles for the response and hands load data to writeback.
`ifndef XLEN
`define XLEN 32
`endif

module data_memory_interface #(
  parameter int XLEN    = `XLEN,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          MemReqValid,
  input  logic                          MemWrite,
  input  logic [1:0]                    AccessSize,
  input  logic [XLEN-1:0]               Address,
  input  logic [XLEN-1:0]               StoreData,
  input  logic                          Flush,
  output logic                          Stall,
  output logic [XLEN-1:0]               LoadData,
  output logic [$clog2(XLEN/8)-1:0]     TruncSrc,
  output logic                          LoadValid,
  output logic                          Misaligned,
  output logic                          AccessFault,
  output logic                          DMemReqValid,
  input  logic                          DMemReqReady,
  output logic [XLEN-1:0]               DMemAddr,
  output logic                          DMemWriteEn,
  output logic [XLEN/8-1:0]             DMemByteEn,
  output logic [XLEN-1:0]               DMemWData,
  input  logic                          DMemRespValid,
  input  logic [XLEN-1:0]               DMemRData
);

  localparam int BEW  = XLEN / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int CNTW = $clog2(TIMEOUT) + 1;
  localparam int SW   = OFFW + 4;  // wide enough for offset + access length

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CNTW-1:0]   cnt_reg, cnt_next;
  logic              flushed_reg, flushed_next;
  logic [XLEN-1:0]   addr_reg;
  logic [XLEN-1:0]   wdata_reg;
  logic [BEW-1:0]    be_reg;
  logic              write_reg;
  logic [OFFW-1:0]   off_reg;
  logic [XLEN-1:0]   load_data_reg;
  logic [OFFW-1:0]   trunc_reg;
  logic              misaligned_reg;
  logic              fault_reg;

  logic [OFFW-1:0]   req_off;
  logic              req_mis;
  logic              accept;
  logic              mis_hit;
  logic              capture;
  logic              fault_set;
  logic [BEW-1:0]    be_comb;
  logic [XLEN-1:0]   wdata_comb;
  logic [SW-1:0]     lane_lo;
  logic [SW-1:0]     lane_hi;

  assign req_off = Address[OFFW-1:0];

  // Alignment check: any offset bit below the access size's natural alignment
  // is a fault; a dword access on a 32-bit datapath is always illegal.
  always_comb begin
    req_mis = 1'b0;
    case (AccessSize)
      2'd0:    req_mis = 1'b0;
      2'd1:    req_mis = req_off[0];
      2'd2:    req_mis = |req_off[1:0];
      default: req_mis = (XLEN < 64) ? 1'b1 : |req_off;
    endcase
  end

  assign accept  = (state_reg == IDLE) && MemReqValid && !Flush && !req_mis;
  assign mis_hit = (state_reg == IDLE) && MemReqValid && !Flush &&  req_mis;

  // Byte lanes covered by the access: [offset, offset + 2**size). Loads
  // always fetch the full word and let the writeback truncator pick bytes.
  assign lane_lo = SW'(req_off);
  assign lane_hi = lane_lo + (SW'(1) << AccessSize);

  generate
    for (genvar gi = 0; gi < BEW; gi++) begin : g_lane
      assign be_comb[gi] = !MemWrite ||
                           ((SW'(gi) >= lane_lo) && (SW'(gi) < lane_hi));
    end
  endgenerate

  assign wdata_comb = StoreData << {req_off, 3'b000};

  // Next-state logic: handshake, response wait with timeout, flush tracking.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    flushed_next = flushed_reg;
    capture      = 1'b0;
    fault_set    = 1'b0;
    case (state_reg)
      IDLE: begin
        flushed_next = 1'b0;
        if (accept) state_next = REQ;
      end
      REQ: begin
        if (DMemReqReady) begin
          // Once the bus has taken the request it must be seen through.
          state_next   = WAIT;
          cnt_next     = '0;
          flushed_next = Flush;
        end else if (Flush) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (Flush) flushed_next = 1'b1;
        if (DMemRespValid) begin
          if (flushed_reg || Flush) begin
            state_next = IDLE;
          end else begin
            state_next = DONE;
            capture    = !write_reg;
          end
        end else if (cnt_reg == CNTW'(TIMEOUT - 1)) begin
          state_next = IDLE;
          fault_set  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      flushed_reg    <= 1'b0;
      misaligned_reg <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      flushed_reg    <= flushed_next;
      misaligned_reg <= mis_hit;
      fault_reg      <= fault_set;
    end
  end

  // Request fields latched at acceptance so the bus sees them stable in REQ.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      write_reg <= 1'b0;
      off_reg   <= '0;
    end else if (accept) begin
      addr_reg  <= {Address[XLEN-1:OFFW], {OFFW{1'b0}}};
      wdata_reg <= wdata_comb;
      be_reg    <= be_comb;
      write_reg <= MemWrite;
      off_reg   <= req_off;
    end
  end

  // Load result registers hold until the next captured load response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_data_reg <= '0;
      trunc_reg     <= '0;
    end else if (capture) begin
      load_data_reg <= DMemRData;
      trunc_reg     <= off_reg;
    end
  end

  // Stall is gated by reset so it drops the instant reset asserts.
  assign Stall        = reset && ((state_reg == REQ) || (state_reg == WAIT) || accept);
  assign DMemReqValid = (state_reg == REQ);
  assign DMemWriteEn  = (state_reg == REQ) && write_reg;
  assign DMemAddr     = addr_reg;
  assign DMemByteEn   = be_reg;
  assign DMemWData    = wdata_reg;
  assign LoadValid    = (state_reg == DONE) && !write_reg;
  assign LoadData     = load_data_reg;
  assign TruncSrc     = trunc_reg;
  assign Misaligned   = misaligned_reg;
  assign AccessFault  = fault_reg;

endmodule

// File: tb/tb_data_memory_interface.sv
// Directed bench for data_memory_interface (32-bit datapath, short timeout).
module tb_data_memory_interface;

  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            MemReqValid = 1'b0;
  logic            MemWrite = 1'b0;
  logic [1:0]      AccessSize = 2'd0;
  logic [XLEN-1:0] Address = '0;
  logic [XLEN-1:0] StoreData = '0;
  logic            Flush = 1'b0;
  logic            Stall;
  logic [XLEN-1:0] LoadData;
  logic [1:0]      TruncSrc;
  logic            LoadValid;
  logic            Misaligned;
  logic            AccessFault;
  logic            DMemReqValid;
  logic            DMemReqReady = 1'b0;
  logic [XLEN-1:0] DMemAddr;
  logic            DMemWriteEn;
  logic [3:0]      DMemByteEn;
  logic [XLEN-1:0] DMemWData;
  logic            DMemRespValid = 1'b0;
  logic [XLEN-1:0] DMemRData = '0;

  int n_vec = 0;
  int n_err = 0;

  data_memory_interface #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .MemReqValid(MemReqValid), .MemWrite(MemWrite), .AccessSize(AccessSize),
    .Address(Address), .StoreData(StoreData), .Flush(Flush),
    .Stall(Stall), .LoadData(LoadData), .TruncSrc(TruncSrc),
    .LoadValid(LoadValid), .Misaligned(Misaligned), .AccessFault(AccessFault),
    .DMemReqValid(DMemReqValid), .DMemReqReady(DMemReqReady),
    .DMemAddr(DMemAddr), .DMemWriteEn(DMemWriteEn), .DMemByteEn(DMemByteEn),
    .DMemWData(DMemWData), .DMemRespValid(DMemRespValid), .DMemRData(DMemRData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive just after the rising edge, sample on the falling edge.
  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic request(input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr, input logic [31:0] sd);
    MemReqValid = 1'b1;
    MemWrite    = wr;
    AccessSize  = sz;
    Address     = addr;
    StoreData   = sd;
  endtask

  initial begin
    // Reset values
    mid();
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_loadvalid", 32'(LoadValid), 32'd0);
    check("rst_misaligned", 32'(Misaligned), 32'd0);
    check("rst_fault", 32'(AccessFault), 32'd0);
    check("rst_reqvalid", 32'(DMemReqValid), 32'd0);
    check("rst_we", 32'(DMemWriteEn), 32'd0);
    check("rst_loaddata", LoadData, 32'd0);
    check("rst_trunc", 32'(TruncSrc), 32'd0);
    go(); reset = 1'b1;
    mid();

    // Load word at 0x100: ready immediately, response two cycles after handshake
    go(); request(1'b0, 2'd2, 32'h100, 32'h0); DMemReqReady = 1'b1;
    mid(); check("lw_accept_stall", 32'(Stall), 32'd1);
    check("lw_accept_noreq", 32'(DMemReqValid), 32'd0);
    go(); MemReqValid = 1'b0;
    mid(); check("lw_req_valid", 32'(DMemReqValid), 32'd1);
    check("lw_req_addr", DMemAddr, 32'h100);
    check("lw_req_be", 32'(DMemByteEn), 32'hF);
    check("lw_req_we", 32'(DMemWriteEn), 32'd0);
    check("lw_req_stall", 32'(Stall), 32'd1);
    go(); DMemReqReady = 1'b0;
    mid(); check("lw_wait1_stall", 32'(Stall), 32'd1);
    check("lw_wait1_noreq", 32'(DMemReqValid), 32'd0);
    go(); DMemRespValid = 1'b1; DMemRData = 32'hDEADBEEF;
    mid(); check("lw_wait2_stall", 32'(Stall), 32'd1);
    go(); DMemRespValid = 1'b0; DMemRData = 32'h0;
    mid(); check("lw_done_loadvalid", 32'(LoadValid), 32'd1);
    check("lw_done_data", LoadData, 32'hDEADBEEF);
    check("lw_done_trunc", 32'(TruncSrc), 32'd0);
    check("lw_done_stall", 32'(Stall), 32'd0);
    go();
    mid(); check("lw_idle_loadvalid", 32'(LoadValid), 32'd0);
    check("lw_idle_stall", 32'(Stall), 32'd0);

    // Store half 0xABCD at 0x202
    go(); request(1'b1, 2'd1, 32'h202, 32'h0000ABCD); DMemReqReady = 1'b1;
    mid(); check("sh_accept_stall", 32'(Stall), 32'd1);
    go(); MemReqValid = 1'b0;
    mid(); check("sh_req_valid", 32'(DMemReqValid), 32'd1);
    check("sh_req_we", 32'(DMemWriteEn), 32'd1);
    check("sh_req_be", 32'(DMemByteEn), 32'hC);
    check("sh_req_wdata", DMemWData, 32'hABCD0000);
    check("sh_req_addr", DMemAddr, 32'h200);
    go(); DMemReqReady = 1'b0; DMemRespValid = 1'b1;
    mid(); check("sh_wait_loadvalid", 32'(LoadValid), 32'd0);
    go(); DMemRespValid = 1'b0;
    mid(); check("sh_done_loadvalid", 32'(LoadValid), 32'd0);
    check("sh_done_stall", 32'(Stall), 32'd0);
    check("sh_done_data", LoadData, 32'hDEADBEEF);
    go();
    mid();

    // Misaligned load word at 0x101
    go(); request(1'b0, 2'd2, 32'h101, 32'h0);
    mid(); check("mis_stall", 32'(Stall), 32'd0);
    check("mis_noreq0", 32'(DMemReqValid), 32'd0);
    go(); MemReqValid = 1'b0;
    mid(); check("mis_pulse", 32'(Misaligned), 32'd1);
    check("mis_noreq1", 32'(DMemReqValid), 32'd0);
    check("mis_stall1", 32'(Stall), 32'd0);
    go();
    mid(); check("mis_pulse_end", 32'(Misaligned), 32'd0);
    check("mis_noreq2", 32'(DMemReqValid), 32'd0);

    // Dword on a 32-bit datapath is illegal even when aligned
    go(); request(1'b0, 2'd3, 32'h700, 32'h0);
    mid(); check("dw_stall", 32'(Stall), 32'd0);
    go(); MemReqValid = 1'b0;
    mid(); check("dw_misaligned", 32'(Misaligned), 32'd1);
    check("dw_noreq", 32'(DMemReqValid), 32'd0);
    go();
    mid();

    // Load byte at 0x303 with ready held low for three cycles
    go(); request(1'b0, 2'd0, 32'h303, 32'h0); DMemReqReady = 1'b0;
    mid(); check("lb_accept_stall", 32'(Stall), 32'd1);
    go(); MemReqValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid(); check("lb_hold_valid", 32'(DMemReqValid), 32'd1);
      check("lb_hold_addr", DMemAddr, 32'h300);
      check("lb_hold_be", 32'(DMemByteEn), 32'hF);
      check("lb_hold_we", 32'(DMemWriteEn), 32'd0);
      check("lb_hold_stall", 32'(Stall), 32'd1);
      go();
    end
    DMemReqReady = 1'b1;
    mid(); check("lb_hs_valid", 32'(DMemReqValid), 32'd1);
    go(); DMemReqReady = 1'b0; DMemRespValid = 1'b1; DMemRData = 32'h11223344;
    mid(); check("lb_wait_stall", 32'(Stall), 32'd1);
    go(); DMemRespValid = 1'b0;
    mid(); check("lb_done_loadvalid", 32'(LoadValid), 32'd1);
    check("lb_done_data", LoadData, 32'h11223344);
    check("lb_done_trunc", 32'(TruncSrc), 32'd3);
    go();
    mid();

    // Flush during WAIT on a load
    go(); request(1'b0, 2'd2, 32'h400, 32'h0); DMemReqReady = 1'b1;
    mid();
    go(); MemReqValid = 1'b0;
    mid(); check("fl_req_valid", 32'(DMemReqValid), 32'd1);
    go(); DMemReqReady = 1'b0; Flush = 1'b1;
    mid(); check("fl_wait_stall", 32'(Stall), 32'd1);
    go(); Flush = 1'b0; DMemRespValid = 1'b1; DMemRData = 32'h55555555;
    mid(); check("fl_resp_stall", 32'(Stall), 32'd1);
    go(); DMemRespValid = 1'b0;
    mid(); check("fl_idle_loadvalid", 32'(LoadValid), 32'd0);
    check("fl_idle_stall", 32'(Stall), 32'd0);
    check("fl_idle_data", LoadData, 32'h11223344);
    check("fl_idle_trunc", 32'(TruncSrc), 32'd3);
    go();
    mid(); check("fl_idle2_loadvalid", 32'(LoadValid), 32'd0);
    check("fl_idle2_noreq", 32'(DMemReqValid), 32'd0);

    // Timeout: no response for TO cycles
    go(); request(1'b0, 2'd2, 32'h500, 32'h0); DMemReqReady = 1'b1;
    mid();
    go(); MemReqValid = 1'b0;
    mid(); check("to_req_valid", 32'(DMemReqValid), 32'd1);
    for (int i = 0; i < TO; i++) begin
      go(); DMemReqReady = 1'b0;
      mid(); check("to_wait_stall", 32'(Stall), 32'd1);
      check("to_wait_nofault", 32'(AccessFault), 32'd0);
    end
    go();
    mid(); check("to_fault_pulse", 32'(AccessFault), 32'd1);
    check("to_fault_stall", 32'(Stall), 32'd0);
    go(); DMemRespValid = 1'b1; DMemRData = 32'h99999999;
    mid(); check("to_fault_end", 32'(AccessFault), 32'd0);
    go(); DMemRespValid = 1'b0;
    mid(); check("to_stray_loadvalid", 32'(LoadValid), 32'd0);
    check("to_stray_data", LoadData, 32'h11223344);
    check("to_stray_stall", 32'(Stall), 32'd0);

    // Reset asserted while waiting for a response
    go(); request(1'b0, 2'd0, 32'h601, 32'h0); DMemReqReady = 1'b1;
    mid();
    go(); MemReqValid = 1'b0;
    mid();
    go(); DMemReqReady = 1'b0;
    mid(); check("rw_wait_stall", 32'(Stall), 32'd1);
    reset = 1'b0;
    #1;
    check("rw_stall", 32'(Stall), 32'd0);
    check("rw_reqvalid", 32'(DMemReqValid), 32'd0);
    check("rw_we", 32'(DMemWriteEn), 32'd0);
    check("rw_loadvalid", 32'(LoadValid), 32'd0);
    check("rw_fault", 32'(AccessFault), 32'd0);
    check("rw_misaligned", 32'(Misaligned), 32'd0);
    check("rw_loaddata", LoadData, 32'd0);
    check("rw_trunc", 32'(TruncSrc), 32'd0);
    go(); reset = 1'b1; DMemRespValid = 1'b1; DMemRData = 32'h77777777;
    mid(); check("rw_late_stall", 32'(Stall), 32'd0);
    go(); DMemRespValid = 1'b0;
    mid(); check("rw_late_loadvalid", 32'(LoadValid), 32'd0);
    check("rw_late_data", LoadData, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
